// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, branch redirect and the decode-side
// valid/ready handshake. The fetch unit is the master; memory/decode/branch side is the slave.
interface fetch_unit_if;
    logic [31:0] ReadPC;
    logic [31:0] Instruction;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    modport master (
        output ReadPC,
        input  Instruction,
        input  branch_valid,
        input  branch_target,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc
    );

    modport slave (
        input  ReadPC,
        output Instruction,
        output branch_valid,
        output branch_target,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one-cycle-latency reads to Memoria and
// buffers {pc, instr} pairs in a small FIFO for decode; a redirect flushes everything.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t           buf_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0] pc;
    logic [31:0] inflight_pc;
    logic        inflight;
    logic        kill;

    logic        pop;
    logic        push;
    logic        issue;
    logic [CNT_W:0] occupancy;

    // Only bits [31:2] of a redirect target are meaningful.
    logic unused_target_bits;
    assign unused_target_bits = ^bus.branch_target[1:0];

    assign pop = (count != '0) && bus.inst_ready;

    // Slots already committed (buffered + response on the way), less the one leaving now.
    assign occupancy = {1'b0, count}
                     + {{CNT_W{1'b0}}, inflight}
                     - {{CNT_W{1'b0}}, pop};

    assign issue = !bus.branch_valid && (occupancy < (CNT_W + 1)'(DEPTH));
    assign push  = inflight && !kill && !bus.branch_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            kill        <= 1'b0;
        end else begin
            inflight <= issue;
            kill     <= bus.branch_valid && inflight;
            if (bus.branch_valid) begin
                pc <= {bus.branch_target[31:2], 2'b00};
            end else if (issue) begin
                pc          <= pc + 32'd4;
                inflight_pc <= pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.branch_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage is reset (not left uninitialised like a RAM) because the
    // head word must read as zero out of reset; at this depth it is just flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_q[i] <= '0;
            end
        end else if (push) begin
            buf_q[wr_ptr] <= '{pc: inflight_pc, instr: bus.Instruction};
        end
    end

    assign bus.ReadPC     = pc;
    assign bus.inst_valid = (count != '0);
    assign bus.inst_data  = buf_q[rd_ptr].instr;
    assign bus.inst_pc    = buf_q[rd_ptr].pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a transaction-level model (delivered PCs run sequentially
// from the last reset/redirect, data = memory word) plus directed timing checks.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memoria: synchronous read, word valid the cycle after the address.
    logic [31:0] mem [1024];
    always @(posedge clk) bus.Instruction <= mem[bus.ReadPC[11:2]];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: the next instruction decode must see, and the hold rule under backpressure.
    logic [31:0] exp_pc = RESET_PC;
    logic        held   = 1'b0;
    logic [31:0] held_pc;
    logic [31:0] held_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", 32'(bus.inst_valid), 32'd0);
            check("rst_readpc", bus.ReadPC, RESET_PC);
            exp_pc = RESET_PC;
            held   = 1'b0;
        end else begin
            if (bus.inst_valid) begin
                check("head_pc", bus.inst_pc, exp_pc);
                check("head_data", bus.inst_data, mem[exp_pc[11:2]]);
            end
            if (held) begin
                check("hold_valid", 32'(bus.inst_valid), 32'd1);
                check("hold_pc", bus.inst_pc, held_pc);
                check("hold_data", bus.inst_data, held_data);
            end
            held      = bus.inst_valid && !bus.inst_ready && !bus.branch_valid;
            held_pc   = bus.inst_pc;
            held_data = bus.inst_data;
            if (bus.branch_valid)
                exp_pc = {bus.branch_target[31:2], 2'b00};
            else if (bus.inst_valid && bus.inst_ready)
                exp_pc = exp_pc + 32'd4;
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
        bus.branch_valid  = 1'b0;
        bus.branch_target = 32'h0;
        bus.inst_ready    = 1'b1;

        // Reset values and streaming from RESET_PC.
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(bus.inst_valid), 32'd0);
        check("reset_readpc", bus.ReadPC, 32'h0000_0000);
        check("reset_inst_pc", bus.inst_pc, 32'h0);
        check("reset_inst_data", bus.inst_data, 32'h0);
        rst_n = 1'b1;
        check("c0_readpc", bus.ReadPC, 32'h0);
        check("c0_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        check("c1_readpc", bus.ReadPC, 32'h4);
        check("c1_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        check("c2_valid", 32'(bus.inst_valid), 32'd1);
        check("c2_pc", bus.inst_pc, 32'h0);
        check("c2_data", bus.inst_data, 32'h1000_0000);
        tick();
        check("c3_pc", bus.inst_pc, 32'h4);
        check("c3_data", bus.inst_data, 32'h1000_0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stream_valid", 32'(bus.inst_valid), 32'd1);
        end

        // Backpressure from a fresh reset.
        rst_n = 1'b0;
        bus.inst_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("bp_readpc", bus.ReadPC, 32'h8);
        check("bp_valid", 32'(bus.inst_valid), 32'd1);
        check("bp_head", bus.inst_pc, 32'h0);
        bus.inst_ready = 1'b1;
        tick();
        check("bp_rel1_valid", 32'(bus.inst_valid), 32'd1);
        check("bp_rel1_pc", bus.inst_pc, 32'h4);
        tick();
        check("bp_rel2_valid", 32'(bus.inst_valid), 32'd1);
        check("bp_rel2_pc", bus.inst_pc, 32'h8);
        tick();
        check("bp_rel3_pc", bus.inst_pc, 32'hC);

        // Redirect while a fetch is in flight and one entry is buffered.
        bus.branch_valid  = 1'b1;
        bus.branch_target = 32'h0000_0043;
        tick();
        bus.branch_valid = 1'b0;
        check("br1_r1_valid", 32'(bus.inst_valid), 32'd0);
        check("br1_r1_readpc", bus.ReadPC, 32'h40);
        tick();
        check("br1_r2_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        check("br1_r3_valid", 32'(bus.inst_valid), 32'd1);
        check("br1_r3_pc", bus.inst_pc, 32'h40);
        check("br1_r3_data", bus.inst_data, 32'h1000_0010);
        tick();
        check("br1_r4_pc", bus.inst_pc, 32'h44);

        // Redirect coinciding with a pop on a full buffer.
        bus.inst_ready = 1'b0;
        repeat (3) tick();
        check("br2_head_held", bus.inst_pc, 32'h44);
        bus.inst_ready    = 1'b1;
        bus.branch_valid  = 1'b1;
        bus.branch_target = 32'h0000_0100;
        tick();
        bus.branch_valid = 1'b0;
        check("br2_r1_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        check("br2_r2_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        check("br2_r3_valid", 32'(bus.inst_valid), 32'd1);
        check("br2_r3_pc", bus.inst_pc, 32'h100);
        check("br2_r3_data", bus.inst_data, 32'h1000_0040);

        // PC wrap at the top of the address space.
        bus.branch_valid  = 1'b1;
        bus.branch_target = 32'hFFFF_FFF8;
        tick();
        bus.branch_valid = 1'b0;
        repeat (2) tick();
        check("wrap0_pc", bus.inst_pc, 32'hFFFF_FFF8);
        check("wrap0_data", bus.inst_data, 32'h1000_03FE);
        tick();
        check("wrap1_pc", bus.inst_pc, 32'hFFFF_FFFC);
        check("wrap1_data", bus.inst_data, 32'h1000_03FF);
        tick();
        check("wrap2_valid", 32'(bus.inst_valid), 32'd1);
        check("wrap2_pc", bus.inst_pc, 32'h0000_0000);
        check("wrap2_data", bus.inst_data, 32'h1000_0000);

        // Reset asserted for one cycle with a full buffer.
        bus.inst_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(bus.inst_valid), 32'd0);
        check("mrst_readpc", bus.ReadPC, RESET_PC);
        tick();
        rst_n = 1'b1;
        bus.inst_ready = 1'b1;
        tick();
        check("mrst_c1_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        check("mrst_c2_valid", 32'(bus.inst_valid), 32'd1);
        check("mrst_c2_pc", bus.inst_pc, 32'h0);
        check("mrst_c2_data", bus.inst_data, 32'h1000_0000);
        tick();
        check("mrst_c3_pc", bus.inst_pc, 32'h4);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
